// File: rtl/seq_prod_divider.sv
// Iterative restoring divider: recovers an operand and remainder from a product, one quotient bit per cycle.
// Optional build macro QUOT_SAT_EN clamps the quotient to operand range and raises sat.
module seq_prod_divider #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quot,
    output logic [VW-1:0] rem,
    output logic          dz,
    output logic          sat
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam int PW = VW + 1;
    localparam logic [CW-1:0] CNT_START = CW'(DW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd_sr;
    logic [DW-1:0] quot_sr;
    logic [VW-1:0] dvs;
    logic [PW-1:0] prem;
    logic [PW-1:0] prem_nxt;
    logic [PW:0]   p;
    logic          ge;
    logic [DW-1:0] q_step;
    logic          dz_r;
    logic          accept;
    logic          last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step: bring down the next dividend bit and trial-subtract.
    always_comb begin
        p        = {prem, dvd_sr[DW-1]};
        ge       = (p >= {2'b00, dvs});
        prem_nxt = ge ? PW'(p - {2'b00, dvs}) : PW'(p);
        q_step   = {quot_sr[DW-2:0], ge};
        accept   = (state == IDLE) && in_valid;
        last     = (state == RUN) && (cnt == '0);
    end

`ifdef QUOT_SAT_EN
    localparam logic [DW-1:0] QMAX = DW'((64'd1 << VW) - 64'd1);
    logic sat_r;
    logic sat_hit;
    assign sat_hit = last && (q_step > QMAX);
    assign sat     = sat_r;
`else
    assign sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            dvd_sr  <= '0;
            dvs     <= '0;
            prem    <= '0;
            quot_sr <= '0;
            dz_r    <= 1'b0;
`ifdef QUOT_SAT_EN
            sat_r   <= 1'b0;
`endif
        end else if (accept) begin
            dvd_sr <= dividend;
            dvs    <= divisor;
            cnt    <= CNT_START;
            dz_r   <= (divisor == '0);
`ifdef QUOT_SAT_EN
            sat_r  <= 1'b0;
`endif
            // Divide-by-zero skips RUN, so its result is loaded here directly.
            if (divisor == '0) begin
                quot_sr <= '1;
                prem    <= {1'b0, dividend[VW-1:0]};
            end else begin
                quot_sr <= '0;
                prem    <= '0;
            end
        end else if (state == RUN) begin
            dvd_sr <= {dvd_sr[DW-2:0], 1'b0};
            prem   <= prem_nxt;
            cnt    <= last ? '0 : cnt - 1'b1;
`ifdef QUOT_SAT_EN
            if (sat_hit) begin
                quot_sr <= QMAX;
                sat_r   <= 1'b1;
            end else begin
                quot_sr <= q_step;
            end
`else
            quot_sr <= q_step;
`endif
        end
    end

    assign quot = quot_sr;
    assign rem  = prem[VW-1:0];
    assign dz   = dz_r;

endmodule

// File: tb/tb_seq_prod_divider.sv
// Scoreboard bench for seq_prod_divider; expectations follow QUOT_SAT_EN when the macro is defined.
module tb_seq_prod_divider;
    localparam int DW = 16;
    localparam int VW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] quot;
    logic [VW-1:0] rem;
    logic          dz;
    logic          sat;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        logic          sat;
    } exp_t;

    exp_t sb[$];

    seq_prod_divider #(.DW(DW), .VW(VW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem), .dz(dz), .sat(sat)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a[VW-1:0]; e.dz = 1'b1; e.sat = 1'b0;
        end else begin
            e.q = a / {8'h00, b};
            e.r = VW'(a % {8'h00, b});
            e.dz = 1'b0; e.sat = 1'b0;
`ifdef QUOT_SAT_EN
            if (e.q > 16'h00FF) begin
                e.q = 16'h00FF; e.sat = 1'b1;
            end
`endif
        end
        return e;
    endfunction

    // Called at a negedge with in_ready high; returns at the negedge after the accepting edge.
    task automatic send_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
        dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(model(a, b));
        @(negedge clk);
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
    endtask

    // lat = number of edges after the accepting edge before out_valid is seen.
    task automatic wait_valid(input int limit, output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < limit) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, quot, rem, dz, sat} !== {1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h dz=%b sat=%b want rdy=1 vld=0 q=0000 r=00 dz=0 sat=0",
                     in_ready, out_valid, quot, rem, dz, sat);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat; bit ok; exp_t e;
        out_ready = 1'b1;
        send_op(16'h1C8A, 8'h5B);
        wait_valid(40, lat, ok);
        total++;
        if (!ok || lat != 16) begin
            bad++; $display("FAIL basic_latency got=%0d want=16 (ok=%0b)", lat, ok);
        end
        e = sb.pop_front();
        total++;
        if (quot !== e.q || rem !== e.r || dz !== e.dz || sat !== e.sat) begin
            bad++; $display("FAIL basic_result got q=%h r=%h dz=%b sat=%b want q=%h r=%h dz=%b sat=%b",
                            quot, rem, dz, sat, e.q, e.r, e.dz, e.sat);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL basic_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_full_range;
        int lat; bit ok; exp_t e;
        out_ready = 1'b1;
        send_op(16'hFFFF, 8'h01);
        wait_valid(40, lat, ok);
        e = sb.pop_front();
        total++;
        if (!ok || quot !== e.q || rem !== e.r || dz !== e.dz || sat !== e.sat) begin
            bad++; $display("FAIL full_range got q=%h r=%h dz=%b sat=%b want q=%h r=%h dz=%b sat=%b",
                            quot, rem, dz, sat, e.q, e.r, e.dz, e.sat);
        end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        int lat; bit ok; exp_t e;
        out_ready = 1'b1;
        send_op(16'h1234, 8'h00);
        wait_valid(40, lat, ok);
        total++;
        if (!ok || lat != 0) begin
            bad++; $display("FAIL dz_latency got=%0d want=0 (ok=%0b)", lat, ok);
        end
        e = sb.pop_front();
        total++;
        if (quot !== e.q || rem !== e.r || dz !== e.dz || sat !== e.sat) begin
            bad++; $display("FAIL dz_result got q=%h r=%h dz=%b sat=%b want q=%h r=%h dz=%b sat=%b",
                            quot, rem, dz, sat, e.q, e.r, e.dz, e.sat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_pressure;
        int lat; bit ok; exp_t e;
        out_ready = 1'b0;
        send_op(16'h00E1, 8'h0F);
        wait_valid(40, lat, ok);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== e.q || rem !== e.r || dz !== e.dz) begin
                bad++; $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b q=%h r=%h want vld=1 rdy=0 q=%h r=%h",
                                i, out_valid, in_ready, quot, rem, e.q, e.r);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        send_op(16'h00C8, 8'h14);
        wait_valid(40, lat, ok);
        e = sb.pop_front();
        total++;
        if (!ok || quot !== e.q || rem !== e.r || dz !== e.dz) begin
            bad++; $display("FAIL bp_next got q=%h r=%h dz=%b want q=%h r=%h dz=%b", quot, rem, dz, e.q, e.r, e.dz);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int lat; bit ok; bit seen; exp_t e;
        out_ready = 1'b1;
        send_op(16'h04D2, 8'h07);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({in_ready, out_valid, quot, rem, dz, sat} !== {1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL midrun_reset got rdy=%b vld=%b q=%h r=%h dz=%b sat=%b want rdy=1 vld=0 q=0000 r=00 dz=0 sat=0",
                            in_ready, out_valid, quot, rem, dz, sat);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL midrun_ghost got out_valid=1 want no result after reset");
        end
        send_op(16'h0064, 8'h0A);
        wait_valid(40, lat, ok);
        e = sb.pop_front();
        total++;
        if (!ok || quot !== e.q || rem !== e.r || dz !== e.dz) begin
            bad++; $display("FAIL midrun_next got q=%h r=%h dz=%b want q=%h r=%h dz=%b", quot, rem, dz, e.q, e.r, e.dz);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        bit got;
        exp_t e;
        for (int n = 0; n < 2000; n++) begin
            a = DW'($urandom);
            b = VW'($urandom_range(1, 255));
            if (!in_ready) begin
                total++; bad++;
                $display("FAIL rand_ready op=%0d got in_ready=0 want 1", n);
                @(negedge clk);
            end
            send_op(a, b);
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) got = 1'b1;
                else @(negedge clk);
            end
            total++;
            if (!got) begin
                bad++; $display("FAIL rand_timeout op=%0d got no handshake want result", n);
                sb.delete();
                continue;
            end
            e = sb.pop_front();
            total++;
            if (quot !== e.q || rem !== e.r || dz !== e.dz || sat !== e.sat) begin
                bad++; $display("FAIL rand_result a=%h b=%h got q=%h r=%h sat=%b want q=%h r=%h sat=%b",
                                a, b, quot, rem, sat, e.q, e.r, e.sat);
            end
            if (!sat) begin
                total++;
                if ((int'(quot) * int'(b) + int'(rem)) != int'(a) || rem >= b) begin
                    bad++; $display("FAIL rand_invariant a=%h b=%h got q=%h r=%h want q*b+r=a and r<b",
                                    a, b, quot, rem);
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_range();
        test_div_zero();
        test_back_pressure();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
